prewish5k_button_poller: RTL
============================

Name: prewish5k_button_poller

Overview:
- Mentor-side (initiator) partner of the button debounce block.
- Periodically raises STB_O to request a status byte, waits for the responder's one-cycle STB_I pulse, and captures DAT_I.
- Keeps the last button state and produces per-bit press/release event pulses for the LED/pattern logic.
- Sits between the debounce block and the blinky sequencer.

Parameters:
POLL_PERIOD, 48000, cycles between poll ticks (1 ms at 48 MHz); must exceed STB_CYCLES+TIMEOUT+4
POLL_BITS, 16, width of poll counter
STB_CYCLES, 2, cycles STB_O is held high per request (>=1)
TIMEOUT, 64, cycles to wait for STB_I after STB_O falls
TIMEOUT_BITS, 7, width of timeout counter
REPEAT_DELAY, 500, polls held before first auto-repeat (feature only)
REPEAT_RATE, 100, polls between auto-repeats (feature only)

Ports:
CLK_I  in  1  system clock
RST_I  in  1  reset, asynchronous, active-low
STB_O  out  1  request strobe to responder
DAT_O  out  8  request mask to responder, constant 8'hFF
STB_I  in  1  one-cycle response strobe from responder
DAT_I  in  8  status byte, valid while STB_I=1; active-high buttons
o_buttons  out  8  last captured button state
o_press  out  8  one-cycle pulse per bit on 0->1
o_release  out  8  one-cycle pulse per bit on 1->0
o_timeout  out  1  one-cycle pulse when a poll gets no response
o_alive  out  1  toggles on each successful poll

Behaviour:
- Reset (RST_I=0, async): all outputs 0 except DAT_O=8'hFF; FSM=IDLE; poll counter=POLL_PERIOD-1; timeout and strobe counters=0.
- Poll counter: free-running down-counter; tick when it reaches 0, then reload POLL_PERIOD-1. The first tick occurs POLL_PERIOD cycles after reset release.
- IDLE:
  - On tick: STB_O<=1, strobe counter<=STB_CYCLES-1, go to REQ.
  - A tick in any other state is dropped and not queued.
- REQ:
  - STB_O stays high for exactly STB_CYCLES cycles.
  - When the strobe counter reaches 0: STB_O<=0, timeout counter<=TIMEOUT-1, go to WAIT.
  - STB_I seen in REQ is ignored.
- WAIT:
  - If STB_I=1: capture DAT_I into a new-state register, go to EVAL. STB_I takes priority over timeout expiry in the same cycle.
  - Else if the timeout counter is 0: pulse o_timeout, keep o_buttons unchanged, go to IDLE.
  - Else: decrement the timeout counter.
- EVAL (one cycle):
  - o_press<=new&~old.
  - o_release<=~new&old.
  - o_buttons<=new.
  - Toggle o_alive.
  - Go to IDLE.
  - Event outputs are 0 in every other cycle.
- Latency: STB_I high at edge N gives o_buttons/o_press valid after edge N+1.
- STB_I outside WAIT: ignored, no capture.
- Reset asserted mid-poll: STB_O drops immediately and no events are emitted.
- Unused FSM encodings: return to IDLE with STB_O=0.

Optional Feature:
POLLER_REPEAT_EN
- Defined:
  - Per-bit hold counters, counting polls, for bits that remain 1.
  - After REPEAT_DELAY consecutive held polls, o_press re-pulses for that bit, then again every REPEAT_RATE polls.
  - A counter clears when its bit reads 0 or a timeout occurs.
- Undefined: no hold counters; o_press fires only on 0->1 edges.

Decomposition:
- Shared package/include:
  - FSM state encodings IDLE=2'b00, REQ=2'b01, WAIT=2'b11, EVAL=2'b10.
  - DAT_O mask constant 8'hFF.
  - Simulation overrides under SIM_STEP: POLL_PERIOD=20, TIMEOUT=8.
- Sub-module: prewish5k_poll_timer (free-running tick generator, parameters POLL_PERIOD/POLL_BITS), reused by the blinky sequencer.
- Edge detection and FSM stay in the top module.

Test Plan:
1. Reset release, responder model answers 3 cycles after STB_O falls with DAT_I=8'h01 (POLL_PERIOD=20, STB_CYCLES=2) -> STB_O high during cycles 20-21; o_buttons=8'h01 and o_press=8'h01 for one cycle; o_alive=1.
2. Next poll, DAT_I=8'h01 again -> o_press=0, o_release=0; o_alive toggles back to 0.
3. DAT_I=8'h00 after 8'h01 -> o_release=8'h01 for one cycle; o_buttons=8'h00.
4. Responder silent (TIMEOUT=8) -> o_timeout pulses 8 cycles after STB_O falls; o_buttons holds its prior value; the next poll proceeds normally.
5. Assert RST_I low while in REQ -> STB_O=0 in the same cycle (async); after release, the first STB_O rises POLL_PERIOD cycles later.
6. With POLLER_REPEAT_EN, REPEAT_DELAY=3, REPEAT_RATE=2, bit0 held -> o_press[0] pulses at polls 1, 4, 6, 8.

Source files
------------

// File: rtl/prewish5k_button_poller_pkg.sv
// Shared types and constants for the button poller and its poll timer.
// SIM_STEP shrinks the default poll period and timeout for fast simulation.
package prewish5k_button_poller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b11,
    ST_EVAL = 2'b10
  } poll_state_t;

  localparam logic [7:0] DAT_MASK = 8'hFF;

`ifdef SIM_STEP
  localparam int DEF_POLL_PERIOD = 20;
  localparam int DEF_TIMEOUT     = 8;
`else
  localparam int DEF_POLL_PERIOD = 48000;
  localparam int DEF_TIMEOUT     = 64;
`endif

endpackage

// File: rtl/prewish5k_poll_timer.sv
// Free-running down-counter that emits a one-cycle tick every POLL_PERIOD cycles.
// The first tick lands POLL_PERIOD cycles after reset release.
module prewish5k_poll_timer #(
  parameter int POLL_PERIOD = 48000,
  parameter int POLL_BITS   = 16
) (
  input  logic gclk,
  input  logic grst_n,
  output logic tick
);

  localparam logic [POLL_BITS-1:0] RELOAD = POLL_BITS'(POLL_PERIOD - 1);

  logic [POLL_BITS-1:0] cnt;

  assign tick = (cnt == '0);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt <= RELOAD;
    else         cnt <= tick ? RELOAD : cnt - POLL_BITS'(1);
  end

endmodule

// File: rtl/prewish5k_button_poller.sv
// Initiator side of the button debounce link: polls a status byte, tracks button
// state and emits press/release pulses. POLLER_REPEAT_EN adds held-button auto-repeat.
module prewish5k_button_poller
  import prewish5k_button_poller_pkg::*;
#(
  parameter int POLL_PERIOD  = DEF_POLL_PERIOD,
  parameter int POLL_BITS    = 16,
  parameter int STB_CYCLES   = 2,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int TIMEOUT_BITS = 7
`ifdef POLLER_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] o_buttons,
  output logic [7:0] o_press,
  output logic [7:0] o_release,
  output logic       o_timeout,
  output logic       o_alive
);

  localparam int STB_BITS = (STB_CYCLES > 1) ? $clog2(STB_CYCLES) : 1;
  localparam logic [STB_BITS-1:0]     STB_LOAD = STB_BITS'(STB_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] TO_LOAD  = TIMEOUT_BITS'(TIMEOUT - 1);

  poll_state_t             state_q, state_d;
  logic [STB_BITS-1:0]     stb_cnt_q, stb_cnt_d;
  logic [TIMEOUT_BITS-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]              new_q, new_d;
  logic                    stb_d;
  logic [7:0]              buttons_d, press_d, release_d;
  logic                    timeout_d, alive_d;
  logic [7:0]              rep_fire;
  logic                    tick;

  assign DAT_O = DAT_MASK;

  prewish5k_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD),
    .POLL_BITS   (POLL_BITS)
  ) u_timer (
    .gclk   (CLK_I),
    .grst_n (RST_I),
    .tick   (tick)
  );

`ifdef POLLER_REPEAT_EN
  // Per-bit hold counter: loaded on the first held poll, fires at 1, then reloads with the rate.
  localparam int REP_BITS = 16;
  for (genvar i = 0; i < 8; i++) begin : g_rep
    logic [REP_BITS-1:0] hold;

    assign rep_fire[i] = (state_q == ST_EVAL) && new_q[i] && (hold == REP_BITS'(1));

    always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I)                  hold <= '0;
      else if (o_timeout)          hold <= '0;
      else if (state_q == ST_EVAL) begin
        if (!new_q[i])                 hold <= '0;
        else if (hold == '0)           hold <= REP_BITS'(REPEAT_DELAY);
        else if (hold == REP_BITS'(1)) hold <= REP_BITS'(REPEAT_RATE);
        else                           hold <= hold - REP_BITS'(1);
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin
    state_d   = state_q;
    stb_d     = STB_O;
    stb_cnt_d = stb_cnt_q;
    to_cnt_d  = to_cnt_q;
    new_d     = new_q;
    buttons_d = o_buttons;
    press_d   = '0;
    release_d = '0;
    timeout_d = 1'b0;
    alive_d   = o_alive;
    case (state_q)
      ST_IDLE: begin
        // Ticks outside IDLE are simply lost; nothing queues them.
        if (tick) begin
          stb_d     = 1'b1;
          stb_cnt_d = STB_LOAD;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (stb_cnt_q == '0) begin
          stb_d    = 1'b0;
          to_cnt_d = TO_LOAD;
          state_d  = ST_WAIT;
        end else begin
          stb_cnt_d = stb_cnt_q - STB_BITS'(1);
        end
      end
      ST_WAIT: begin
        // A response in the final timeout cycle still counts.
        if (STB_I) begin
          new_d   = DAT_I;
          state_d = ST_EVAL;
        end else if (to_cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TIMEOUT_BITS'(1);
        end
      end
      ST_EVAL: begin
        press_d   = (new_q & ~o_buttons) | rep_fire;
        release_d = ~new_q & o_buttons;
        buttons_d = new_q;
        alive_d   = ~o_alive;
        state_d   = ST_IDLE;
      end
      default: begin
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q   <= ST_IDLE;
      STB_O     <= 1'b0;
      stb_cnt_q <= '0;
      to_cnt_q  <= '0;
      new_q     <= '0;
      o_buttons <= '0;
      o_press   <= '0;
      o_release <= '0;
      o_timeout <= 1'b0;
      o_alive   <= 1'b0;
    end else begin
      state_q   <= state_d;
      STB_O     <= stb_d;
      stb_cnt_q <= stb_cnt_d;
      to_cnt_q  <= to_cnt_d;
      new_q     <= new_d;
      o_buttons <= buttons_d;
      o_press   <= press_d;
      o_release <= release_d;
      o_timeout <= timeout_d;
      o_alive   <= alive_d;
    end
  end

endmodule
